// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer.
// A prescaler divides Clock into decrement ticks of TICK_DIV cycles. The
// loaded BCD count (00-99) is decremented once per tick while running; on the
// tick that produces 00 the timer enters EXPIRED and pulses Done for one cycle.
//
// Control inputs are level-sampled on every rising edge with the priority
// Load > Start > Pause > tick. A control input that does not apply in the
// current state falls through to the next lower priority. For example, Start
// while RUN is a no-op, so Pause or the tick still act on that edge.
//
// All outputs come straight from flops. Running/Expired/Done are registered
// from the next-state values, so they line up with the Tens/Ones they describe.
// dbg_state mirrors the FSM state register (0 IDLE, 1 RUN, 2 PAUSED, 3 EXPIRED).
module countdown_timer #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int START_TENS = 1,
  parameter int START_ONES = 0
) (
  input  logic       Clock,
  input  logic       Clr,
  input  logic       Load,
  input  logic [3:0] LoadTens,
  input  logic [3:0] LoadOnes,
  input  logic       Start,
  input  logic       Pause,
  output logic [3:0] Tens,
  output logic [3:0] Ones,
  output logic       Running,
  output logic       Done,
  output logic       Expired,
  output logic [1:0] dbg_state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;
  logic          running_q, running_d;
  logic          expired_q, expired_d;

  logic          count_zero;
  logic          start_take;

  // BCD digits above 9 are not representable on the display; treat as 9.
  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign count_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
  // Start only acts when there is something to resume or count down.
  assign start_take = Start &&
                      (((state_q == ST_IDLE) && !count_zero) ||
                       (state_q == ST_PAUSED));

  // State register: FSM state, digits, prescaler and registered outputs.
  always_ff @(posedge Clock or negedge Clr) begin
    if (!Clr) begin
      state_q   <= ST_IDLE;
      tens_q    <= 4'(START_TENS);
      ones_q    <= 4'(START_ONES);
      presc_q   <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      presc_q   <= presc_d;
      done_q    <= done_d;
      running_q <= running_d;
      expired_q <= expired_d;
    end
  end

  // Next-state: prioritised Load / Start / Pause / tick handling and BCD decrement.
  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    presc_d = presc_q;
    done_d  = 1'b0;

    if (Load) begin
      tens_d  = clamp_bcd(LoadTens);
      ones_d  = clamp_bcd(LoadOnes);
      presc_d = '0;
      state_d = ST_IDLE;
    end else if (start_take) begin
      state_d = ST_RUN;
      // A fresh start counts a full tick period; a resume keeps the partial one.
      if (state_q == ST_IDLE) begin
        presc_d = '0;
      end
    end else if (state_q == ST_RUN) begin
      if (Pause) begin
        // Prescaler holds and any due tick is dropped for this edge.
        state_d = ST_PAUSED;
      end else if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        if (ones_q != 4'd0) begin
          ones_d = ones_q - 4'd1;
        end else if (tens_q != 4'd0) begin
          ones_d = 4'd9;
          tens_d = tens_q - 4'd1;
        end
        if ((tens_d == 4'd0) && (ones_d == 4'd0)) begin
          state_d = ST_EXPIRED;
          done_d  = 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // Output decode: status flags follow the state being entered this edge.
  always_comb begin
    running_d = (state_d == ST_RUN);
    expired_d = (state_d == ST_EXPIRED);
  end

  assign Tens      = tens_q;
  assign Ones      = ones_q;
  assign Running   = running_q;
  assign Done      = done_q;
  assign Expired   = expired_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICK_DIV=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_countdown_timer;

  logic       Clock;
  logic       Clr;
  logic       Load;
  logic [3:0] LoadTens;
  logic [3:0] LoadOnes;
  logic       Start;
  logic       Pause;
  logic [3:0] Tens;
  logic [3:0] Ones;
  logic       Running;
  logic       Done;
  logic       Expired;
  logic [1:0] dbg_state;

  int checks;
  int errors;
  int done_cnt;
  logic last_done;

  countdown_timer #(
    .TICK_DIV  (4),
    .START_TENS(1),
    .START_ONES(0)
  ) dut (
    .Clock    (Clock),
    .Clr      (Clr),
    .Load     (Load),
    .LoadTens (LoadTens),
    .LoadOnes (LoadOnes),
    .Start    (Start),
    .Pause    (Pause),
    .Tens     (Tens),
    .Ones     (Ones),
    .Running  (Running),
    .Done     (Done),
    .Expired  (Expired),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Advance n rising edges, landing 1 unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check count and the three status flags together.
  task automatic check_all(input string tag, input logic [7:0] cnt,
                           input logic run, input logic dn, input logic exp);
    check({tag, ".count"}, {Tens, Ones}, cnt);
    check({tag, ".running"}, {7'd0, Running}, {7'd0, run});
    check({tag, ".done"}, {7'd0, Done}, {7'd0, dn});
    check({tag, ".expired"}, {7'd0, Expired}, {7'd0, exp});
  endtask

  task automatic do_load(input logic [3:0] t, input logic [3:0] o);
    Load = 1'b1; LoadTens = t; LoadOnes = o;
    step(1);
    Load = 1'b0;
  endtask

  task automatic do_start();
    Start = 1'b1;
    step(1);
    Start = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    Clr = 1'b1; Load = 1'b0; LoadTens = 4'd0; LoadOnes = 4'd0;
    Start = 1'b0; Pause = 1'b0;

    // Async reset with no clock edge yet (first edge at t=5)
    #1 Clr = 1'b0;
    #1;
    check_all("reset", 8'h10, 1'b0, 1'b0, 1'b0);
    check("reset.state", {6'd0, dbg_state}, 8'd0);
    #1 Clr = 1'b1;
    step(1);
    check_all("idle_after_reset", 8'h10, 1'b0, 1'b0, 1'b0);

    // Basic countdown 03 -> 00
    do_load(4'd0, 4'd3);
    check_all("load03", 8'h03, 1'b0, 1'b0, 1'b0);
    do_start();
    check_all("start03", 8'h03, 1'b1, 1'b0, 1'b0);
    step(3);
    check_all("k3", 8'h03, 1'b1, 1'b0, 1'b0);
    step(1);
    check_all("k4", 8'h02, 1'b1, 1'b0, 1'b0);
    step(4);
    check_all("k8", 8'h01, 1'b1, 1'b0, 1'b0);
    step(3);
    check_all("k11", 8'h01, 1'b1, 1'b0, 1'b0);
    step(1);
    check_all("k12", 8'h00, 1'b0, 1'b1, 1'b1);
    step(1);
    check_all("k13", 8'h00, 1'b0, 1'b0, 1'b1);
    do_start();
    check_all("start_in_expired", 8'h00, 1'b0, 1'b0, 1'b1);
    step(5);
    check_all("expired_hold", 8'h00, 1'b0, 1'b0, 1'b1);

    // Borrow: 10 -> 09 -> ... -> 00
    do_load(4'd1, 4'd0);
    check_all("load10", 8'h10, 1'b0, 1'b0, 1'b0);
    do_start();
    step(4);
    check_all("borrow09", 8'h09, 1'b1, 1'b0, 1'b0);
    done_cnt = 0; last_done = 1'b0;
    for (int i = 0; i < 36; i++) begin
      step(1);
      if (Done) done_cnt++;
      last_done = Done;
    end
    check_all("borrow00", 8'h00, 1'b0, 1'b1, 1'b1);
    check("borrow.done_pulses", 8'(done_cnt), 8'd1);
    check("borrow.last_done", {7'd0, last_done}, 8'd1);

    // Pause / resume keeps the partial prescaler count
    do_load(4'd0, 4'd5);
    do_start();
    step(2);
    Pause = 1'b1;
    step(10);
    check_all("paused", 8'h05, 1'b0, 1'b0, 1'b0);
    check("paused.state", {6'd0, dbg_state}, 8'd2);
    Pause = 1'b0;
    do_start();
    check_all("resume", 8'h05, 1'b1, 1'b0, 1'b0);
    step(1);
    check_all("resume1", 8'h05, 1'b1, 1'b0, 1'b0);
    step(1);
    check_all("resume2", 8'h04, 1'b1, 1'b0, 1'b0);

    // Load on an edge where a tick is due, with out-of-range digits
    step(3);
    check_all("tick_due", 8'h04, 1'b1, 1'b0, 1'b0);
    do_load(4'hF, 4'hC);
    check_all("load_clamp", 8'h99, 1'b0, 1'b0, 1'b0);
    check("load_clamp.state", {6'd0, dbg_state}, 8'd0);
    Pause = 1'b1;
    step(6);
    Pause = 1'b0;
    check_all("idle_no_count", 8'h99, 1'b0, 1'b0, 1'b0);

    // Start with 00 stays IDLE
    do_load(4'd0, 4'd0);
    do_start();
    check_all("start00", 8'h00, 1'b0, 1'b0, 1'b0);
    check("start00.state", {6'd0, dbg_state}, 8'd0);

    // Async reset in the middle of RUN
    do_load(4'd0, 4'd2);
    do_start();
    step(2);
    check_all("pre_reset", 8'h02, 1'b1, 1'b0, 1'b0);
    #2 Clr = 1'b0;
    #1;
    check_all("mid_reset", 8'h10, 1'b0, 1'b0, 1'b0);
    check("mid_reset.state", {6'd0, dbg_state}, 8'd0);
    #1 Clr = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (Done) done_cnt++;
    end
    check("post_reset.done_pulses", 8'(done_cnt), 8'd0);
    check_all("post_reset", 8'h10, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
